// File: rtl/count_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_chk_pkg
//  Description : Shared state encoding for the counter sequence checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package count_chk_pkg;

    // Width of the checker state register
    localparam int c_STATE_W = 2;

    // Lock-tracking states: no seed yet, building a run, tracking the counter
    typedef enum logic [c_STATE_W-1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Event counter that sticks at all-ones; clear beats inc.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] c_MAX = {W{1'b1}};

    // Count events, never rolling over; a clear drops a same-cycle event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && (value != c_MAX)) begin
            value <= value + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_checker
//  Description : Locks onto a modulo counter's 0..MODULUS-1 sequence and
//                reports breaks, out-of-range samples and completed wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MODULUS    = 15,
    parameter int RESYNC_LEN = 2,
    parameter int WRAP_CNT_W = 16,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  clear,
    output logic                  locked,
    output logic                  mismatch,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic [ERR_CNT_W-1:0]  error_count,
    output logic                  oor_sticky
);

    // Run counter only needs to reach RESYNC_LEN
    localparam int               c_GOOD_W   = (RESYNC_LEN > 1) ? $clog2(RESYNC_LEN + 1) : 1;
    localparam logic [WIDTH-1:0] c_LAST     = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable (no oor possible)
    localparam logic [WIDTH:0]   c_MOD      = (WIDTH + 1)'(MODULUS);
    localparam logic [c_GOOD_W-1:0] c_GOOD_TGT = c_GOOD_W'(RESYNC_LEN);
    // A single legal sample is enough to lock
    localparam bit               c_INSTANT  = (RESYNC_LEN == 1);

    state_t              r_state;
    logic [WIDTH-1:0]    r_exp;
    logic [c_GOOD_W-1:0] r_good;

    logic                w_oor;
    logic                w_hit;
    logic [WIDTH-1:0]    w_nxt;
    logic [c_GOOD_W-1:0] w_good_inc;
    logic                w_mis_evt;
    logic                w_wrap_evt;

    // Classify the current sample against range and the expected value
    always_comb begin
        w_oor      = ({1'b0, count_in} >= c_MOD);
        w_hit      = (count_in == r_exp);
        w_nxt      = (count_in == c_LAST) ? '0 : (count_in + WIDTH'(1));
        w_good_inc = r_good + c_GOOD_W'(1);
        // r_exp is always a legal value, so a hit is never out of range
        w_mis_evt  = sample_valid && (r_state == LOCKED) && !w_hit;
        w_wrap_evt = sample_valid && (r_state == LOCKED) && w_hit && (count_in == '0);
    end

    // Lock FSM with expectation tracking and registered event pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= UNLOCKED;
            r_exp      <= '0;
            r_good     <= '0;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            mismatch   <= w_mis_evt;
            wrap_pulse <= w_wrap_evt;
            if (sample_valid) begin
                case (r_state)
                    UNLOCKED: begin
                        if (!w_oor) begin
                            r_exp   <= w_nxt;
                            r_good  <= c_GOOD_W'(1);
                            r_state <= c_INSTANT ? LOCKED : ACQUIRE;
                            locked  <= c_INSTANT;
                        end
                    end
                    ACQUIRE: begin
                        if (w_oor) begin
                            r_state <= UNLOCKED;
                            locked  <= 1'b0;
                        end else if (w_hit) begin
                            r_exp  <= w_nxt;
                            r_good <= w_good_inc;
                            if (w_good_inc == c_GOOD_TGT) begin
                                r_state <= LOCKED;
                                locked  <= 1'b1;
                            end
                        end else begin
                            // Off-sequence while acquiring: restart the run here
                            r_exp  <= w_nxt;
                            r_good <= c_GOOD_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (w_hit) begin
                            r_exp <= w_nxt;
                        end else if (w_oor) begin
                            r_state <= UNLOCKED;
                            locked  <= 1'b0;
                        end else begin
                            // Legal but unexpected: treat it as a fresh seed
                            r_exp   <= w_nxt;
                            r_good  <= c_GOOD_W'(1);
                            r_state <= c_INSTANT ? LOCKED : ACQUIRE;
                            locked  <= c_INSTANT;
                        end
                    end
                    default: begin
                        r_state <= UNLOCKED;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky out-of-range flag, cleared only by clear or reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oor_sticky <= 1'b0;
        end else if (clear) begin
            oor_sticky <= 1'b0;
        end else if (sample_valid && w_oor) begin
            oor_sticky <= 1'b1;
        end
    end

    sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_wrap_evt),
        .clear (clear),
        .value (wrap_count)
    );

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_mis_evt),
        .clear (clear),
        .value (error_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_count_seq_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_count_seq_checker
//  Description : Randomised and directed bench for count_seq_checker against
//                a run-length reference model. Two configurations share the
//                stimulus: A (MOD 15, resync 2, 2-bit errors) and
//                B (MOD 10, resync 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_seq_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  count_in = 4'd0;

    logic        a_locked, a_mis, a_wrap, a_oor;
    logic [15:0] a_wc;
    logic [1:0]  a_ec;
    logic        b_locked, b_mis, b_wrap, b_oor;
    logic [15:0] b_wc;
    logic [7:0]  b_ec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    count_seq_checker #(
        .WIDTH(4), .MODULUS(15), .RESYNC_LEN(2), .WRAP_CNT_W(16), .ERR_CNT_W(2)
    ) u_dut_a (
        .clk(clk), .reset(rst), .sample_valid(sample_valid), .count_in(count_in),
        .clear(clear), .locked(a_locked), .mismatch(a_mis), .wrap_pulse(a_wrap),
        .wrap_count(a_wc), .error_count(a_ec), .oor_sticky(a_oor)
    );

    count_seq_checker #(
        .WIDTH(4), .MODULUS(10), .RESYNC_LEN(1), .WRAP_CNT_W(16), .ERR_CNT_W(8)
    ) u_dut_b (
        .clk(clk), .reset(rst), .sample_valid(sample_valid), .count_in(count_in),
        .clear(clear), .locked(b_locked), .mismatch(b_mis), .wrap_pulse(b_wrap),
        .wrap_count(b_wc), .error_count(b_ec), .oor_sticky(b_oor)
    );

    // Model view: "run" = length of the current in-sequence run of legal
    // samples (0 = nothing seeded), "last" = most recent legal sample.
    typedef struct {
        bit locked;
        bit mis;
        bit wrap;
        int wc;
        int ec;
        bit oor;
        int run;
        int last;
    } model_t;

    model_t m_a;
    model_t m_b;

    function automatic model_t mstep(model_t m, bit v, int c, bit clr,
                                     int md, int rlen, int wmax, int emax);
        model_t n;
        bit legal;
        bit follows;
        bit inc_w;
        bit inc_e;
        n = m;
        n.mis = 1'b0;
        n.wrap = 1'b0;
        inc_w = 1'b0;
        inc_e = 1'b0;
        legal = (c < md);
        follows = legal && (m.run > 0) && (c == (m.last + 1) % md);
        if (v) begin
            if (!legal) n.oor = 1'b1;
            if (m.locked) begin
                if (follows) begin
                    if (c == 0) begin
                        n.wrap = 1'b1;
                        inc_w = 1'b1;
                    end
                end else begin
                    n.mis = 1'b1;
                    inc_e = 1'b1;
                    n.run = legal ? 1 : 0;
                    n.locked = legal && (rlen == 1);
                end
            end else begin
                if (!legal) n.run = 0;
                else if (follows) n.run = m.run + 1;
                else n.run = 1;
                n.locked = (n.run >= rlen);
            end
            if (legal) n.last = c;
        end
        if (clr) begin
            n.wc = 0;
            n.ec = 0;
            n.oor = 1'b0;
        end else begin
            if (inc_w && n.wc < wmax) n.wc = n.wc + 1;
            if (inc_e && n.ec < emax) n.ec = n.ec + 1;
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(string tag, model_t m, logic l, logic mi, logic w,
                       logic [31:0] wc, logic [31:0] ec, logic o);
        chk({tag, ".locked"},      32'(l),  32'(m.locked));
        chk({tag, ".mismatch"},    32'(mi), 32'(m.mis));
        chk({tag, ".wrap_pulse"},  32'(w),  32'(m.wrap));
        chk({tag, ".wrap_count"},  wc,      32'(m.wc));
        chk({tag, ".error_count"}, ec,      32'(m.ec));
        chk({tag, ".oor_sticky"},  32'(o),  32'(m.oor));
    endtask

    task automatic cmp_both();
        cmp("A", m_a, a_locked, a_mis, a_wrap, 32'(a_wc), 32'(a_ec), a_oor);
        cmp("B", m_b, b_locked, b_mis, b_wrap, 32'(b_wc), 32'(b_ec), b_oor);
    endtask

    // One clock: drive, let the edge happen, advance the model, compare
    task automatic step(bit v, int c, bit clr);
        sample_valid = v;
        count_in     = 4'(c);
        clear        = clr;
        @(posedge clk);
        m_a = mstep(m_a, v, c, clr, 15, 2, 65535, 3);
        m_b = mstep(m_b, v, c, clr, 10, 1, 65535, 255);
        #1;
        cmp_both();
    endtask

    task automatic model_reset();
        m_a = '{default: 0};
        m_b = '{default: 0};
    endtask

    function automatic int n15(int x);
        return (x + 1) % 15;
    endfunction

    initial begin
        int cur;
        int nw;
        int nm;
        int bad;
        int z;
        int gmod;
        bit v;

        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.locked", 32'(a_locked), 0);
        chk("rst.wrap_count", 32'(a_wc), 0);
        chk("rst.error_count", 32'(a_ec), 0);
        chk("rst.oor_sticky", 32'(a_oor), 0);
        cmp_both();
        rst = 1'b0;

        // 1: clean run 0..14,0..4
        nw = 0;
        nm = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, i % 15, 1'b0);
            nw += int'(a_wrap);
            nm += int'(a_mis);
            if (i == 1) chk("t1.lock_after_1", 32'(a_locked), 1);
            if (i == 15) chk("t1.wrap_on_2nd_0", 32'(a_wrap), 1);
        end
        chk("t1.wrap_pulses", 32'(nw), 1);
        chk("t1.mismatches", 32'(nm), 0);
        chk("t1.wrap_count", 32'(a_wc), 1);
        chk("t1.error_count", 32'(a_ec), 0);

        // 2: counter reset mid-period
        step(1'b1, 5, 1'b0);
        step(1'b1, 0, 1'b0);
        chk("t2.mismatch", 32'(a_mis), 1);
        chk("t2.unlocked", 32'(a_locked), 0);
        chk("t2.error_count", 32'(a_ec), 1);
        step(1'b1, 1, 1'b0);
        chk("t2.relock", 32'(a_locked), 1);
        chk("t2.single_pulse", 32'(a_mis), 0);
        step(1'b1, 2, 1'b0);

        // 3: gap with junk on count_in
        step(1'b1, 3, 1'b0);
        repeat (4) step(1'b0, 9, 1'b0);
        step(1'b1, 4, 1'b0);
        chk("t3.locked", 32'(a_locked), 1);
        chk("t3.mismatch", 32'(a_mis), 0);
        chk("t3.error_count", 32'(a_ec), 1);

        // 4: out-of-range while locked, relock, then clear
        step(1'b1, 5, 1'b0);
        step(1'b1, 6, 1'b0);
        step(1'b1, 7, 1'b0);
        step(1'b1, 15, 1'b0);
        chk("t4.mismatch", 32'(a_mis), 1);
        chk("t4.error_count", 32'(a_ec), 2);
        chk("t4.oor_set", 32'(a_oor), 1);
        chk("t4.unlocked", 32'(a_locked), 0);
        step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);
        chk("t4.relock", 32'(a_locked), 1);
        chk("t4.oor_held", 32'(a_oor), 1);
        step(1'b0, 0, 1'b1);
        chk("t4.oor_cleared", 32'(a_oor), 0);
        cur = 1;

        // 5: build wc=5 / ec=3, then clear on a wrapping 0
        repeat (3) begin
            bad = (cur + 5) % 15;
            step(1'b1, bad, 1'b0);
            cur = n15(bad);
            step(1'b1, cur, 1'b0);
        end
        chk("t5.error_count3", 32'(a_ec), 3);
        z = 0;
        while (z < 5) begin
            cur = n15(cur);
            step(1'b1, cur, 1'b0);
            if (cur == 0) z++;
        end
        chk("t5.wrap_count5", 32'(a_wc), 5);
        while (cur != 14) begin
            cur = n15(cur);
            step(1'b1, cur, 1'b0);
        end
        step(1'b1, 0, 1'b1);
        cur = 0;
        chk("t5.wrap_pulse", 32'(a_wrap), 1);
        chk("t5.wrap_cleared", 32'(a_wc), 0);
        chk("t5.err_cleared", 32'(a_ec), 0);
        repeat (5) begin
            bad = (cur + 5) % 15;
            step(1'b1, bad, 1'b0);
            cur = n15(bad);
            step(1'b1, cur, 1'b0);
        end
        chk("t5.err_saturated", 32'(a_ec), 3);

        // 6: asynchronous reset pulse between edges
        chk("t6.locked_before", 32'(a_locked), 1);
        #1;
        rst = 1'b1;
        model_reset();
        #3;
        chk("t6.locked", 32'(a_locked), 0);
        chk("t6.error_count", 32'(a_ec), 0);
        chk("t6.wrap_count", 32'(a_wc), 0);
        chk("t6.oor_sticky", 32'(a_oor), 0);
        cmp_both();
        rst = 1'b0;
        step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);
        chk("t6.relock", 32'(a_locked), 1);
        cur = 1;

        // Random phase: mostly a clean counter of period 15 or 10 with gaps,
        // glitches, out-of-range values, clears and occasional resets
        for (int k = 0; k < 3000; k++) begin
            gmod = ((k / 200) % 2 == 1) ? 10 : 15;
            v = ($urandom_range(0, 99) < 85);
            if (v) begin
                if ($urandom_range(0, 99) < 85) cur = (cur + 1) % gmod;
                else cur = int'($urandom_range(0, 15));
                step(1'b1, cur, ($urandom_range(0, 99) < 3));
            end else begin
                step(1'b0, int'($urandom_range(0, 15)), ($urandom_range(0, 99) < 3));
            end
            if ($urandom_range(0, 999) < 5) begin
                #1;
                rst = 1'b1;
                model_reset();
                #2;
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
